// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU decoder: the one-hot ALU operation
// struct, major opcode constants, operand-select encodings and the decoded
// bundle that travels through the output buffer.
package alu_pkg;

    // One-hot ALU operation. Exactly one primary bit is set for a legal
    // instruction; branches additionally set one of the _B compare bits.
    typedef struct packed {
        logic ADD;
        logic SUB;
        logic SLL;
        logic SLT;
        logic SLTU;
        logic XOR;
        logic SRL;
        logic SRA;
        logic OR;
        logic AND;
        logic SLT_B;
        logic SLTU_B;
        logic SEQ_B;
    } InstructionSetALU;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values that distinguish ADD/SUB and SRL/SRA
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Operand A select
    localparam logic [1:0] IN1_RS1  = 2'd0;
    localparam logic [1:0] IN1_PC   = 2'd1;
    localparam logic [1:0] IN1_ZERO = 2'd2;

    // Operand B select
    localparam logic IN2_RS2 = 1'b0;
    localparam logic IN2_IMM = 1'b1;

    // Everything the decoder hands to the consumer for one instruction
    typedef struct packed {
        InstructionSetALU op;
        logic [31:0]      imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [1:0]       in1_sel;
        logic             in2_sel;
        logic             b_invert;
        logic             illegal;
    } decode_t;

    // Register-register and register-immediate arithmetic share the funct3 map;
    // alt selects SUB/SRA over ADD/SRL.
    function automatic InstructionSetALU alu_op_from_f3(input logic [2:0] f3, input logic alt);
        InstructionSetALU op;
        op = '0;
        case (f3)
            3'd0: if (alt) op.SUB = 1'b1; else op.ADD = 1'b1;
            3'd1: op.SLL  = 1'b1;
            3'd2: op.SLT  = 1'b1;
            3'd3: op.SLTU = 1'b1;
            3'd4: op.XOR  = 1'b1;
            3'd5: if (alt) op.SRA = 1'b1; else op.SRL = 1'b1;
            3'd6: op.OR   = 1'b1;
            default: op.AND = 1'b1;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I decode of one instruction word into a decode_t
// bundle. Unrecognised encodings collapse to a NOP (op, imm and selects zero).
// Build option: ALU_DECODER_ILLEGAL_EN drives the illegal flag; without it the
// flag stays 0 while illegal encodings still decode to NOP.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode/funct decode with a final squash of everything illegal to NOP
    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];

        case (opcode)
            OPC_OP: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5))) begin
                    legal       = 1'b1;
                    dec.op      = alu_op_from_f3(f3, f7 == F7_ALT);
                    dec.in1_sel = IN1_RS1;
                    dec.in2_sel = IN2_RS2;
                end
            end
            OPC_OP_IMM: begin
                dec.in1_sel = IN1_RS1;
                dec.in2_sel = IN2_IMM;
                if (f3 == 3'd1) begin
                    legal   = (f7 == F7_BASE);
                    dec.op  = alu_op_from_f3(f3, 1'b0);
                    dec.imm = {27'b0, instr[24:20]};
                end else if (f3 == 3'd5) begin
                    legal   = (f7 == F7_BASE) || (f7 == F7_ALT);
                    dec.op  = alu_op_from_f3(f3, f7 == F7_ALT);
                    dec.imm = {27'b0, instr[24:20]};
                end else begin
                    // Immediate forms never use SUB, so alt is forced low
                    legal   = 1'b1;
                    dec.op  = alu_op_from_f3(f3, 1'b0);
                    dec.imm = imm_i;
                end
            end
            OPC_BRANCH: begin
                legal       = (f3 != 3'd2) && (f3 != 3'd3);
                dec.op.ADD  = 1'b1;
                dec.in1_sel = IN1_PC;
                dec.in2_sel = IN2_IMM;
                dec.imm     = imm_b;
                // funct3[0] marks the negated compare (BNE/BGE/BGEU)
                dec.b_invert = f3[0];
                case (f3[2:1])
                    2'b00:   dec.op.SEQ_B  = 1'b1;
                    2'b10:   dec.op.SLT_B  = 1'b1;
                    2'b11:   dec.op.SLTU_B = 1'b1;
                    default: dec.op.SEQ_B  = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal       = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                dec.op.ADD  = 1'b1;
                dec.in1_sel = IN1_RS1;
                dec.in2_sel = IN2_IMM;
                dec.imm     = imm_i;
            end
            OPC_STORE: begin
                legal       = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
                dec.op.ADD  = 1'b1;
                dec.in1_sel = IN1_RS1;
                dec.in2_sel = IN2_IMM;
                dec.imm     = imm_s;
            end
            OPC_JALR: begin
                legal       = (f3 == 3'd0);
                dec.op.ADD  = 1'b1;
                dec.in1_sel = IN1_RS1;
                dec.in2_sel = IN2_IMM;
                dec.imm     = imm_i;
            end
            OPC_LUI: begin
                legal       = 1'b1;
                dec.op.ADD  = 1'b1;
                dec.in1_sel = IN1_ZERO;
                dec.in2_sel = IN2_IMM;
                dec.imm     = imm_u;
            end
            OPC_AUIPC: begin
                legal       = 1'b1;
                dec.op.ADD  = 1'b1;
                dec.in1_sel = IN1_PC;
                dec.in2_sel = IN2_IMM;
                dec.imm     = imm_u;
            end
            OPC_JAL: begin
                legal       = 1'b1;
                dec.op.ADD  = 1'b1;
                dec.in1_sel = IN1_PC;
                dec.in2_sel = IN2_IMM;
                dec.imm     = imm_j;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.op       = '0;
            dec.imm      = '0;
            dec.in1_sel  = IN1_RS1;
            dec.in2_sel  = IN2_RS2;
            dec.b_invert = 1'b0;
        end

`ifdef ALU_DECODER_ILLEGAL_EN
        dec.illegal = !legal;
`else
        dec.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/alu_decoder.sv
// Registered RV32I ALU decoder: valid/ready on both sides with a two-entry
// buffer (output register plus skid register) so in_ready can be a flop.
// Build option: ALU_DECODER_ILLEGAL_EN (handled inside alu_decode_comb).
module alu_decoder
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output InstructionSetALU op,
    output logic [31:0]      imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [1:0]       in1_sel,
    output logic             in2_sel,
    output logic             b_invert,
    output logic             illegal
);

    decode_t dec_in;
    decode_t out_data_reg, out_data_next;
    decode_t skid_data_reg, skid_data_next;
    logic    out_valid_reg, out_valid_next;
    logic    skid_valid_reg, skid_valid_next;
    logic    in_ready_reg;
    logic    accept;
    logic    drain;

    alu_decode_comb u_decode (
        .instr (in_instr),
        .dec   (dec_in)
    );

    assign accept = in_valid & in_ready_reg;
    assign drain  = out_valid_reg & out_ready;

    // Buffer next state: the output register is refilled from the skid entry
    // first so the oldest instruction always leaves first
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (!out_valid_reg || drain) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_data_next   = skid_data_reg;
                skid_valid_next = accept;
                if (accept) begin
                    skid_data_next = dec_in;
                end
            end else begin
                out_valid_next = accept;
                if (accept) begin
                    out_data_next = dec_in;
                end
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = dec_in;
        end
    end

    // Buffer state; in_ready is held low in reset and then mirrors skid-empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            in_ready_reg   <= 1'b0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            in_ready_reg   <= !skid_valid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign op        = out_data_reg.op;
    assign imm       = out_data_reg.imm;
    assign rs1       = out_data_reg.rs1;
    assign rs2       = out_data_reg.rs2;
    assign rd        = out_data_reg.rd;
    assign in1_sel   = out_data_reg.in1_sel;
    assign in2_sel   = out_data_reg.in2_sel;
    assign b_invert  = out_data_reg.b_invert;
    assign illegal   = out_data_reg.illegal;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed testbench for alu_decoder: reset state, single-instruction decode
// vectors, back-pressure streaming and reset with a full buffer.
module tb_alu_decoder;
    import alu_pkg::*;

`ifdef ALU_DECODER_ILLEGAL_EN
    localparam logic ILLEGAL_EXP = 1'b1;
`else
    localparam logic ILLEGAL_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    InstructionSetALU op;
    logic [31:0]      imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [1:0]       in1_sel;
    logic             in2_sel;
    logic             b_invert;
    logic             illegal;

    int checks_cnt = 0;
    int errors_cnt = 0;

    alu_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .imm       (imm),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .in1_sel   (in1_sel),
        .in2_sel   (in2_sel),
        .b_invert  (b_invert),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Push one instruction with the consumer ready, check the bundle one
    // cycle later, then let it drain
    task automatic run_vec(input string tag, input logic [31:0] instr,
                           input InstructionSetALU op_exp, input logic [31:0] imm_exp,
                           input logic [1:0] in1_exp, input logic in2_exp,
                           input logic binv_exp, input logic ill_exp);
        check_value({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = instr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check_value({tag, "_op"}, 32'(op), 32'(op_exp));
        check_value({tag, "_imm"}, imm, imm_exp);
        check_value({tag, "_in1_sel"}, 32'(in1_sel), 32'(in1_exp));
        check_value({tag, "_in2_sel"}, 32'(in2_sel), 32'(in2_exp));
        check_value({tag, "_b_invert"}, 32'(b_invert), 32'(binv_exp));
        check_value({tag, "_illegal"}, 32'(illegal), 32'(ill_exp));
        $display("vec %-6s instr=%08h op=%04h imm=%08h rs1=%0d rs2=%0d rd=%0d sel=%0d/%0d inv=%0d ill=%0d",
                 tag, instr, op, imm, rs1, rs2, rd, in1_sel, in2_sel, b_invert, illegal);
        @(posedge clk); #1;
        check_value({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0]      stream [4];
    InstructionSetALU e;
    int               sent;
    int               got;
    logic             acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_in_ready", 32'(in_ready), 32'd0);
        check_value("rst_op", 32'(op), 32'd0);
        check_value("rst_imm", imm, 32'd0);
        check_value("rst_regs", {17'd0, rs1, rs2, rd}, 32'd0);
        check_value("rst_sel", {28'd0, in1_sel, in2_sel, b_invert}, 32'd0);
        check_value("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_value("rel_in_ready", 32'(in_ready), 32'd1);
        $display("reset released, in_ready=%0d", in_ready);

        // add x3,x1,x2 plus register fields
        e = '0; e.ADD = 1'b1;
        run_vec("add", 32'h002081B3, e, 32'h0, IN1_RS1, IN2_RS2, 1'b0, 1'b0);
        // register indices were checked while valid inside a second push
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3;
        @(posedge clk); #1; in_valid = 1'b0;
        check_value("add_rs1", 32'(rs1), 32'd1);
        check_value("add_rs2", 32'(rs2), 32'd2);
        check_value("add_rd", 32'(rd), 32'd3);
        $display("vec add    regs rs1=%0d rs2=%0d rd=%0d", rs1, rs2, rd);
        @(posedge clk); #1;

        e = '0; e.SUB = 1'b1;
        run_vec("sub", 32'h402081B3, e, 32'h0, IN1_RS1, IN2_RS2, 1'b0, 1'b0);
        e = '0; e.SRA = 1'b1;
        run_vec("srai", 32'h40335293, e, 32'h00000003, IN1_RS1, IN2_IMM, 1'b0, 1'b0);
        e = '0; e.ADD = 1'b1;
        run_vec("addi", 32'hFFF00093, e, 32'hFFFFFFFF, IN1_RS1, IN2_IMM, 1'b0, 1'b0);
        e = '0; e.ADD = 1'b1; e.SLT_B = 1'b1;
        run_vec("bge", 32'h0020D063, e, 32'h0, IN1_PC, IN2_IMM, 1'b1, 1'b0);
        e = '0; e.ADD = 1'b1; e.SEQ_B = 1'b1;
        run_vec("beq", 32'hFE000EE3, e, 32'hFFFFFFFC, IN1_PC, IN2_IMM, 1'b0, 1'b0);
        e = '0; e.ADD = 1'b1;
        run_vec("lui", 32'h123450B7, e, 32'h12345000, IN1_ZERO, IN2_IMM, 1'b0, 1'b0);
        e = '0; e.ADD = 1'b1;
        run_vec("sw", 32'h0020A423, e, 32'h00000008, IN1_RS1, IN2_IMM, 1'b0, 1'b0);
        e = '0;
        run_vec("zero", 32'h00000000, e, 32'h0, IN1_RS1, IN2_RS2, 1'b0, ILLEGAL_EXP);
        e = '0;
        run_vec("mul", 32'h022081B3, e, 32'h0, IN1_RS1, IN2_RS2, 1'b0, ILLEGAL_EXP);

        // Back-pressure stream: addi x1..x4 with immediates 1..4 identify order
        stream[0] = 32'h00100093;
        stream[1] = 32'h00200113;
        stream[2] = 32'h00300193;
        stream[3] = 32'h00400213;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 4);
            in_instr  = (sent < 4) ? stream[sent[1:0]] : 32'h0;
            if (cyc == 2 || cyc == 3) begin
                check_value("stream_stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (cyc == 3) begin
                check_value("stream_accepted", 32'(sent), 32'd2);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_value("stream_order_imm", imm, 32'(got + 1));
                $display("stream out #%0d imm=%0d rd=%0d", got, imm, rd);
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check_value("stream_count", 32'(got), 32'd4);
        check_value("stream_empty", 32'(out_valid), 32'd0);

        // Fill both entries, then reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = stream[0];
        @(posedge clk); #1;
        in_instr  = stream[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("full_out_valid", 32'(out_valid), 32'd1);
        check_value("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_value("midrst_out_valid", 32'(out_valid), 32'd0);
        check_value("midrst_in_ready", 32'(in_ready), 32'd0);
        $display("mid-stream reset asserted, out_valid=%0d", out_valid);
        @(posedge clk); #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #1;
            check_value("postrst_out_valid", 32'(out_valid), 32'd0);
            if (cyc == 0) begin
                check_value("postrst_in_ready", 32'(in_ready), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, in_instr holds an instruction.
REQ-004 SHALL have port in_ready, output, 1, decoder can accept an instruction this cycle.
REQ-005 SHALL have port in_instr, input, 32, RV32I instruction word.
REQ-006 SHALL have port out_valid, output, 1, decoded bundle valid.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts the bundle.
REQ-008 SHALL have port op, output, InstructionSetALU, one-hot ALU operation; secondary _B bit added for branches.
REQ-009 SHALL have port imm, output, 32, sign-extended immediate.
REQ-010 SHALL have ports rs1, rs2, rd, output, 5 each, register indices.
REQ-011 SHALL have port in1_sel, output, 2, 0=rs1, 1=pc, 2=zero.
REQ-012 SHALL have port in2_sel, output, 1, 0=rs2, 1=imm.
REQ-013 SHALL have port b_invert, output, 1, invert out_b for BNE/BGE/BGEU.
REQ-014 SHALL have port illegal, output, 1, bundle is an illegal instruction.

Function
REQ-015 Transfer occurs on valid&ready at each side; a bundle appears at the outputs 1 cycle after its input transfer when outputs are empty.
REQ-016 Storage is a 2-entry buffer (output register + skid register); in_ready = skid register empty, registered.
REQ-017 With output full and out_ready=0, one further instruction is accepted into skid; in_ready drops next cycle; no instruction is ever lost or duplicated; order is preserved.
REQ-018 Simultaneous output drain and input accept at full output: skid (if occupied) moves to output, new instruction enters skid or output in order.
REQ-019 OP (0110011): funct3/funct7 select ADD, SUB(f7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA(f7=0100000), OR, AND; in2_sel=0.
REQ-020 OP-IMM (0010011): ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI; in2_sel=1; shifts place shamt in imm[4:0] and zero imm[31:5].
REQ-021 BRANCH (1100011): op.ADD plus SEQ_B (BEQ/BNE), SLT_B (BLT/BGE), SLTU_B (BLTU/BGEU); in1_sel=1, in2_sel=1, B-type imm.
REQ-022 LOAD, STORE, JALR: op.ADD, in1_sel=0, in2_sel=1; LUI: ADD, in1_sel=2; AUIPC, JAL: ADD, in1_sel=1.
REQ-023 Every unlisted opcode/funct combination is illegal: op=0 (NOP), imm=0, sel fields 0.
REQ-024 op SHALL be exactly one primary bit, plus at most one _B bit, or all zero.

Reset
REQ-025 While rst_n=0: out_valid=0, in_ready=0, op=0, imm=0, rs1=rs2=rd=0, in1_sel=0, in2_sel=0, b_invert=0, illegal=0, both buffer entries empty.
REQ-026 in_ready=1 on the first rising edge after rst_n deasserts; reset mid-stream discards all buffered instructions.

Configuration
REQ-027 Macro ALU_DECODER_ILLEGAL_EN defined: illegal follows REQ-023 detection.
REQ-028 Macro ALU_DECODER_ILLEGAL_EN undefined: illegal tied 0; illegal encodings still decode to NOP and flow normally.

Structure
REQ-029 Package alu_pkg SHALL hold InstructionSetALU (fields ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,SLT_B,SLTU_B,SEQ_B), opcode constants, sel encodings.
REQ-030 Combinational decode SHALL be sub-module alu_decode_comb; alu_decoder contains only buffering and handshake.

Verification
REQ-031 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, op.ADD only, rs1=1, rs2=2, rd=3, in2_sel=0.
REQ-032 0x40335293 (srai x5,x6,3) -> op.SRA, imm=0x00000003, in2_sel=1; 0xFFF00093 (addi x1,x0,-1) -> op.ADD, imm=0xFFFFFFFF.
REQ-033 0x0020D063 (bge x1,x2,0) -> op.ADD+SLT_B, b_invert=1, in1_sel=1.
REQ-034 0x00000000 -> op=0, illegal=1 with macro, illegal=0 without.
REQ-035 Stream 4 instructions, out_ready=0 for 3 cycles -> exactly 2 accepted, in_ready=0 until drain, then all 4 emerge in order.
REQ-036 rst_n pulsed low with both entries full -> out_valid=0 immediately; nothing emitted after release.
